// File: rtl/primo_dispatch.sv
// primo_dispatch: keeps one primogen running ahead, queues its primes and hands each one to a
// single requester with a one-cycle grant. Define PRIMO_DISPATCH_RR_EN for round-robin; fixed priority otherwise.
module primo_dispatch #(
   parameter int WIDTH_LOG = 4,
   parameter int NREQ      = 4,
   parameter int DEPTH_LOG = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        pg_go,
   input  logic                        pg_ready,
   input  logic                        pg_error,
   input  logic [(1<<WIDTH_LOG)-1:0]   pg_res,
   input  logic [NREQ-1:0]             req,
   output logic [NREQ-1:0]             gnt,
   output logic [(1<<WIDTH_LOG)-1:0]   data,
   output logic                        exhausted,
   output logic [15:0]                 served
);
   localparam int W     = 1 << WIDTH_LOG;
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_ISSUE  = 2'd0,
      S_SETTLE = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 pg_go_q, pg_go_d;
   logic [W-1:0]         mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [W-1:0]         data_q, data_d;
   logic                 exhausted_q, exhausted_d;
   logic [15:0]          served_q, served_d;
   logic                 push_s, grant_s, empty_s, full_s, found_s;
   logic [PW-1:0]        win_s;

   assign empty_s = (count_q == '0);
   assign full_s  = count_q[DEPTH_LOG];
   assign push_s  = (state_q == S_WAIT) && pg_ready && !pg_error;
   assign grant_s = !empty_s && (|req);

`ifdef PRIMO_DISPATCH_RR_EN
   logic [PW-1:0]     ptr_q;
   logic [2*NREQ-1:0] rot_s;

   assign rot_s = {req, req} >> ptr_q;

   // Round-robin winner: first requester at or after ptr_q, wrapping.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         win_s   = (!found_s && rot_s[k]) ? PW'((int'(ptr_q) + k) % NREQ) : win_s;
         found_s = found_s | rot_s[k];
      end
   end

   // Pointer moves past each winner so it ranks last next time.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant_s) begin
         ptr_q <= PW'((int'(win_s) + 32'sd1) % NREQ);
      end else begin
         ptr_q <= ptr_q;
      end
   end
`else
   // Fixed-priority winner: lowest set request index.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int k = 0; k < NREQ; k++) begin
         win_s   = (!found_s && req[k]) ? PW'(k) : win_s;
         found_s = found_s | req[k];
      end
   end
`endif

   // Sequencer: one primogen operation in flight; SETTLE skips the stale ready of the go cycle.
   always_comb begin
      state_d = state_q;
      pg_go_d = 1'b0;
      case (state_q)
         S_ISSUE: begin
            if (pg_ready && !pg_error && !full_s) begin
               pg_go_d = 1'b1;
               state_d = S_SETTLE;
            end else if (pg_ready && pg_error) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_SETTLE: state_d = S_WAIT;
         S_WAIT: begin
            if (pg_ready && pg_error) begin
               state_d = S_DONE;
            end else if (push_s) begin
               state_d = S_ISSUE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_ISSUE;
      endcase
   end

   // Occupancy, grant outputs and the sticky exhausted flag.
   always_comb begin
      count_d     = count_q;
      gnt_d       = '0;
      data_d      = '0;
      served_d    = served_q;
      exhausted_d = exhausted_q;
      case ({push_s, grant_s})
         2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1'b1);
         2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1'b1);
         default: count_d = count_q;
      endcase
      if (grant_s) begin
         gnt_d    = NREQ'(1'b1) << win_s;
         data_d   = mem_q[rd_ptr_q];
         served_d = served_q + 16'd1;
      end else begin
         gnt_d    = '0;
         data_d   = '0;
         served_d = served_q;
      end
      if ((state_q == S_DONE) && empty_s && !grant_s) begin
         exhausted_d = 1'b1;
      end else begin
         exhausted_d = exhausted_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ISSUE;
         pg_go_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         gnt_q       <= '0;
         data_q      <= '0;
         exhausted_q <= 1'b0;
         served_q    <= 16'd0;
      end else begin
         state_q     <= state_d;
         pg_go_q     <= pg_go_d;
         wr_ptr_q    <= push_s  ? wr_ptr_q + DEPTH_LOG'(1'b1) : wr_ptr_q;
         rd_ptr_q    <= grant_s ? rd_ptr_q + DEPTH_LOG'(1'b1) : rd_ptr_q;
         count_q     <= count_d;
         gnt_q       <= gnt_d;
         data_q      <= data_d;
         exhausted_q <= exhausted_d;
         served_q    <= served_d;
      end
   end

   // Queue storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= pg_res;
      end
   end

   assign pg_go     = pg_go_q;
   assign gnt       = gnt_q;
   assign data      = data_q;
   assign exhausted = exhausted_q;
   assign served    = served_q;
endmodule

// File: tb/tb_primo_dispatch.sv
// Directed bench for primo_dispatch: a W=16 instance and a W=8 instance, each driven by a
// behavioural primogen. Expected grant order follows PRIMO_DISPATCH_RR_EN.
`timescale 1ns/1ps
module tb_primo_dispatch;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int primes [5] = '{2, 3, 5, 7, 11};

   logic        a_go, a_ready, a_error, a_exh;
   logic [15:0] a_res, a_data, a_served;
   logic [3:0]  a_req, a_gnt;
   int          a_cnt, a_last, a_np;

   logic        b_go, b_ready, b_error, b_exh;
   logic [7:0]  b_res, b_data;
   logic [15:0] b_served;
   logic [3:0]  b_req, b_gnt;
   int          b_cnt, b_last, b_np;

   primo_dispatch u_dut (
      .clk(clk), .rst(rst), .pg_go(a_go), .pg_ready(a_ready), .pg_error(a_error),
      .pg_res(a_res), .req(a_req), .gnt(a_gnt), .data(a_data), .exhausted(a_exh),
      .served(a_served)
   );

   primo_dispatch #(.WIDTH_LOG(3)) u_dut8 (
      .clk(clk), .rst(rst), .pg_go(b_go), .pg_ready(b_ready), .pg_error(b_error),
      .pg_res(b_res), .req(b_req), .gnt(b_gnt), .data(b_data), .exhausted(b_exh),
      .served(b_served)
   );

   function automatic int next_prime(input int p);
      int c;
      bit is_p;
      c = p;
      is_p = 1'b0;
      while (!is_p) begin
         c = c + 1;
         is_p = (c >= 2);
         for (int d = 2; d * d <= c; d++) if (c % d == 0) is_p = 1'b0;
      end
      return c;
   endfunction

   assign a_np = next_prime(a_last);
   assign b_np = next_prime(b_last);

   // Behavioural primogen models: busy LAT cycles after go, then ready with the next prime or error.
   always @(posedge clk) begin
      if (rst) begin
         a_ready <= 1'b1; a_error <= 1'b0; a_res <= '0; a_last <= 1; a_cnt <= 0;
      end else if (a_ready && !a_error && a_go) begin
         a_ready <= 1'b0; a_cnt <= LAT;
      end else if (!a_ready && a_cnt > 1) begin
         a_cnt <= a_cnt - 1;
      end else if (!a_ready) begin
         a_ready <= 1'b1;
         if (a_np > 65535) a_error <= 1'b1;
         else begin a_res <= a_np[15:0]; a_last <= a_np; end
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         b_ready <= 1'b1; b_error <= 1'b0; b_res <= '0; b_last <= 1; b_cnt <= 0;
      end else if (b_ready && !b_error && b_go) begin
         b_ready <= 1'b0; b_cnt <= LAT;
      end else if (!b_ready && b_cnt > 1) begin
         b_cnt <= b_cnt - 1;
      end else if (!b_ready) begin
         b_ready <= 1'b1;
         if (b_np > 255) b_error <= 1'b1;
         else begin b_res <= b_np[7:0]; b_last <= b_np; end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; a_req = '0; b_req = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (a_go !== 1'b0 || a_gnt !== 4'b0000 || a_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: pg_go=%b gnt=%b data=%0d, expected 0 0000 0", a_go, a_gnt, a_data);
      end
      checks++;
      if (a_exh !== 1'b0 || a_served !== 16'd0) begin
         errors++;
         $display("FAIL reset_status: exhausted=%b served=%0d, expected 0 0", a_exh, a_served);
      end
      checks++;
      if (b_exh !== 1'b0 || b_served !== 16'd0 || b_gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_w8: exhausted=%b served=%0d gnt=%b, expected 0 0 0000", b_exh, b_served, b_gnt);
      end
   endtask

   task automatic test_single_req();
      int k, bad;
      logic prev;
      do_reset();
      a_req = 4'b0001;
      k = 0; bad = 0; prev = 1'b0;
      for (int c = 0; c < 400 && k < 5; c++) begin
         @(negedge clk);
         if (a_go && prev) bad++;
         prev = a_go;
         if (a_gnt !== 4'b0000) begin
            checks++;
            if (a_gnt !== 4'b0001 || a_data !== 16'(primes[k])) begin
               errors++;
               $display("FAIL single_req_%0d: gnt=%b data=%0d, expected 0001 %0d", k, a_gnt, a_data, primes[k]);
            end
            k++;
            if (k == 5) begin
               checks++;
               if (a_served !== 16'd5) begin
                  errors++;
                  $display("FAIL single_req_served: served=%0d, expected 5", a_served);
               end
            end
         end
      end
      a_req = '0;
      checks++;
      if (k != 5) begin
         errors++;
         $display("FAIL single_req_timeout: grants=%0d, expected 5", k);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL go_back_to_back: count=%0d, expected 0", bad);
      end
   endtask

   task automatic test_prefill_arb();
      logic [3:0] eg;
      do_reset();
      repeat (60) @(negedge clk);
      a_req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
`ifdef PRIMO_DISPATCH_RR_EN
         eg = 4'b0001;
         eg = eg << i;
`else
         eg = 4'b0001;
`endif
         checks++;
         if (a_gnt !== eg || a_data !== 16'(primes[i])) begin
            errors++;
            $display("FAIL arb_order_%0d: gnt=%b data=%0d, expected %b %0d", i, a_gnt, a_data, eg, primes[i]);
         end
      end
      a_req = '0;
      @(negedge clk);
      checks++;
      if (a_gnt !== 4'b0000) begin
         errors++;
         $display("FAIL arb_drained: gnt=%b, expected 0000", a_gnt);
      end
   endtask

   task automatic test_idle_fill();
      int n;
      do_reset();
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_go) n++;
      end
      checks++;
      if (n != 4 || a_go !== 1'b0) begin
         errors++;
         $display("FAIL idle_fill_go: pulses=%0d pg_go=%b, expected 4 0", n, a_go);
      end
      a_req = 4'b0100;
      @(negedge clk);
      a_req = '0;
      checks++;
      if (a_gnt !== 4'b0100 || a_data !== 16'd2) begin
         errors++;
         $display("FAIL idle_first_grant: gnt=%b data=%0d, expected 0100 2", a_gnt, a_data);
      end
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (a_go) n++;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL idle_refill_go: pulses=%0d, expected 1", n);
      end
      a_req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (a_gnt !== 4'b0001 || a_data !== 16'(primes[i+1])) begin
            errors++;
            $display("FAIL idle_drain_%0d: gnt=%b data=%0d, expected 0001 %0d", i, a_gnt, a_data, primes[i+1]);
         end
      end
      a_req = '0;
   endtask

   task automatic test_exhaust();
      int ng, bad, extra;
      logic [7:0] last;
      bit seen;
      do_reset();
      b_req = 4'b0001;
      ng = 0; bad = 0; extra = 0; last = 8'd0; seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (b_gnt !== 4'b0000) begin ng++; last = b_data; end
         if (b_error && b_go) bad++;
         if (b_exh) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL exhaust_timeout: exhausted=%b, expected 1", b_exh);
      end
      checks++;
      if (ng != 54 || last !== 8'd251) begin
         errors++;
         $display("FAIL exhaust_grants: grants=%0d last=%0d, expected 54 251", ng, last);
      end
      checks++;
      if (b_served !== 16'd54) begin
         errors++;
         $display("FAIL exhaust_served: served=%0d, expected 54", b_served);
      end
      repeat (20) begin
         @(negedge clk);
         if (b_gnt !== 4'b0000 || b_go) extra++;
      end
      checks++;
      if (bad != 0 || extra != 0 || b_exh !== 1'b1) begin
         errors++;
         $display("FAIL exhaust_quiet: go_after_err=%0d activity=%0d exhausted=%b, expected 0 0 1", bad, extra, b_exh);
      end
      b_req = '0;
   endtask

   task automatic test_mid_reset();
      int n;
      bit got, done;
      do_reset();
      a_req = 4'b0001;
      n = 0; got = 1'b0;
      for (int c = 0; c < 300 && n < 5; c++) begin
         @(negedge clk);
         if (a_go) n++;
         if (a_gnt !== 4'b0000 && !got) begin got = 1'b1; a_req = '0; end
      end
      checks++;
      if (n != 5 || a_served !== 16'd1) begin
         errors++;
         $display("FAIL mid_reset_setup: pulses=%0d served=%0d, expected 5 1", n, a_served);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (a_gnt !== 4'b0000 || a_served !== 16'd0 || a_exh !== 1'b0 || a_go !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_state: gnt=%b served=%0d exhausted=%b pg_go=%b, expected 0000 0 0 0",
                  a_gnt, a_served, a_exh, a_go);
      end
      a_req = 4'b0001;
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (a_gnt !== 4'b0000) begin
            done = 1'b1;
            checks++;
            if (a_data !== 16'd2) begin
               errors++;
               $display("FAIL mid_reset_first: data=%0d, expected 2", a_data);
            end
         end
      end
      a_req = '0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL mid_reset_timeout: no grant, expected one");
      end
   endtask

   task automatic test_push_race();
      bit ok;
      do_reset();
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (a_go) ok = 1'b1;
      end
      @(negedge clk);
      for (int c = 0; c < 20 && ok && !a_ready; c++) @(negedge clk);
      checks++;
      if (!ok || !a_ready) begin
         errors++;
         $display("FAIL race_setup: go_seen=%b ready=%b, expected 1 1", ok, a_ready);
      end else begin
         a_req = 4'b0010;
         @(negedge clk);
         a_req = '0;
         checks++;
         if (a_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL race_no_grant: gnt=%b, expected 0000", a_gnt);
         end
         @(negedge clk);
         checks++;
         if (a_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL race_idle: gnt=%b, expected 0000", a_gnt);
         end
         a_req = 4'b0010;
         @(negedge clk);
         a_req = '0;
         checks++;
         if (a_gnt !== 4'b0010 || a_data !== 16'd2) begin
            errors++;
            $display("FAIL race_grant: gnt=%b data=%0d, expected 0010 2", a_gnt, a_data);
         end
      end
   endtask

   initial begin
      a_req = '0;
      b_req = '0;
      test_reset();
      test_single_req();
      test_prefill_arb();
      test_idle_fill();
      test_exhaust();
      test_mid_reset();
      test_push_race();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
